// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control strobe bundle between control_sequencer and DataPath
interface control_sequencer_if #(
    parameter int OPW = 5,
    parameter int IRW = 32
);
    logic [IRW-1:0] ir;
    logic           con;
    logic           stop;

    logic PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Yin, Cout, ZLOin, ZLOout, PCin, conin, R15in;
    logic [OPW-1:0] aluControl;
    logic run;
    logic illegal;

    modport master (
        input  ir, con, stop,
        output PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Yin, Cout, ZLOin, ZLOout, PCin, conin, R15in,
        output aluControl, run, illegal
    );

    modport slave (
        output ir, con, stop,
        input  PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Yin, Cout, ZLOin, ZLOout, PCin, conin, R15in,
        input  aluControl, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Mini SRC hardwired Moore control unit (optional CU_SINGLE_STEP_EN)
module control_sequencer #(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic clock,
    input  logic clear,
`ifdef CU_SINGLE_STEP_EN
    input  logic step,
`endif
    control_sequencer_if.master bus
);

    typedef enum logic [4:0] {
        RESET_S, T0, T1, T2, DEC,
        BR3, BR4, BR5, BR6,
        ALU3, ALU4, ALU5,
        JR3, JAL3, JAL4,
        HALT,
        WAIT_S
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    state_t state, state_next, eoi_next;
    logic [OPW-1:0] op;
    logic unused_ir_bits;

    assign op = bus.ir[IRW-1 -: OPW];
    assign unused_ir_bits = ^bus.ir[IRW-OPW-1:0];

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= RESET_S;
        end else begin
            state <= state_next;
        end
    end

    // stop only takes effect at an instruction boundary
    always_comb begin
        eoi_next = T0;
`ifdef CU_SINGLE_STEP_EN
        eoi_next = WAIT_S;
`endif
        if (bus.stop) begin
            eoi_next = HALT;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RESET_S: state_next = T0;
            T0:      state_next = T1;
            T1:      state_next = T2;
            T2:      state_next = DEC;
            DEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = ALU3;
                    OP_BR:   state_next = BR3;
                    OP_JR:   state_next = JR3;
                    OP_JAL:  state_next = JAL3;
                    OP_HALT: state_next = HALT;
                    default: state_next = eoi_next;
                endcase
            end
            BR3:  state_next = BR4;
            BR4:  state_next = BR5;
            BR5:  state_next = BR6;
            BR6:  state_next = eoi_next;
            ALU3: state_next = ALU4;
            ALU4: state_next = ALU5;
            ALU5: state_next = eoi_next;
            JR3:  state_next = eoi_next;
            JAL3: state_next = JAL4;
            JAL4: state_next = eoi_next;
            HALT: state_next = HALT;
`ifdef CU_SINGLE_STEP_EN
            WAIT_S: state_next = step ? T0 : WAIT_S;
`endif
            default: state_next = RESET_S;
        endcase
    end

    always_comb begin
        bus.PCout      = 1'b0;
        bus.IncPC      = 1'b0;
        bus.MARin      = 1'b0;
        bus.read       = 1'b0;
        bus.RAMenable  = 1'b0;
        bus.MDRin      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IRin       = 1'b0;
        bus.Gra        = 1'b0;
        bus.Grb        = 1'b0;
        bus.Grc        = 1'b0;
        bus.Rin        = 1'b0;
        bus.Rout       = 1'b0;
        bus.BAout      = 1'b0;
        bus.Yin        = 1'b0;
        bus.Cout       = 1'b0;
        bus.ZLOin      = 1'b0;
        bus.ZLOout     = 1'b0;
        bus.PCin       = 1'b0;
        bus.conin      = 1'b0;
        bus.R15in      = 1'b0;
        bus.aluControl = '0;
        bus.illegal    = 1'b0;
        bus.run        = (state != RESET_S) && (state != HALT);
        case (state)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            T1: begin
                bus.read      = 1'b1;
                bus.RAMenable = 1'b1;
                bus.MDRin     = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            DEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_BR, OP_JR, OP_JAL, OP_NOP, OP_HALT: bus.illegal = 1'b0;
                    default: bus.illegal = 1'b1;
                endcase
            end
            BR3: begin
                bus.Gra   = 1'b1;
                bus.Rout  = 1'b1;
                bus.conin = 1'b1;
            end
            BR4: begin
                bus.PCout = 1'b1;
                bus.Yin   = 1'b1;
            end
            BR5: begin
                bus.Cout       = 1'b1;
                bus.ZLOin      = 1'b1;
                bus.aluControl = OP_ADD;
            end
            BR6: begin
                bus.ZLOout = 1'b1;
                bus.PCin   = bus.con;
            end
            ALU3: begin
                bus.Grb  = 1'b1;
                bus.Rout = 1'b1;
                bus.Yin  = 1'b1;
            end
            ALU4: begin
                bus.Grc        = 1'b1;
                bus.Rout       = 1'b1;
                bus.ZLOin      = 1'b1;
                bus.aluControl = op;
            end
            ALU5: begin
                bus.ZLOout = 1'b1;
                bus.Gra    = 1'b1;
                bus.Rin    = 1'b1;
            end
            JR3, JAL4: begin
                bus.Gra  = 1'b1;
                bus.Rout = 1'b1;
                bus.PCin = 1'b1;
            end
            JAL3: begin
                bus.PCout = 1'b1;
                bus.R15in = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    localparam logic [20:0] S_PCOUT  = 21'd1 << 20;
    localparam logic [20:0] S_INCPC  = 21'd1 << 19;
    localparam logic [20:0] S_MARIN  = 21'd1 << 18;
    localparam logic [20:0] S_READ   = 21'd1 << 17;
    localparam logic [20:0] S_RAMEN  = 21'd1 << 16;
    localparam logic [20:0] S_MDRIN  = 21'd1 << 15;
    localparam logic [20:0] S_MDROUT = 21'd1 << 14;
    localparam logic [20:0] S_IRIN   = 21'd1 << 13;
    localparam logic [20:0] S_GRA    = 21'd1 << 12;
    localparam logic [20:0] S_GRB    = 21'd1 << 11;
    localparam logic [20:0] S_GRC    = 21'd1 << 10;
    localparam logic [20:0] S_RIN    = 21'd1 << 9;
    localparam logic [20:0] S_ROUT   = 21'd1 << 8;
    localparam logic [20:0] S_YIN    = 21'd1 << 6;
    localparam logic [20:0] S_COUT   = 21'd1 << 5;
    localparam logic [20:0] S_ZLOIN  = 21'd1 << 4;
    localparam logic [20:0] S_ZLOOUT = 21'd1 << 3;
    localparam logic [20:0] S_PCIN   = 21'd1 << 2;
    localparam logic [20:0] S_CONIN  = 21'd1 << 1;
    localparam logic [20:0] S_R15IN  = 21'd1 << 0;

    localparam logic [20:0] E_T0 = S_PCOUT | S_MARIN | S_INCPC;
    localparam logic [20:0] E_T1 = S_READ | S_RAMEN | S_MDRIN;
    localparam logic [20:0] E_T2 = S_MDROUT | S_IRIN;

    localparam logic [31:0] IR_BR   = 32'h9000_0005;
    localparam logic [31:0] IR_ADD  = 32'h1800_0000;
    localparam logic [31:0] IR_JAL  = 32'hA000_0000;
    localparam logic [31:0] IR_NOP  = 32'hC800_0000;
    localparam logic [31:0] IR_HALT = 32'hD000_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;

    logic clock = 1'b0;
    logic clear;
`ifdef CU_SINGLE_STEP_EN
    logic step = 1'b1;
`endif
    int checks = 0;
    int failures = 0;

    control_sequencer_if #(.OPW(5), .IRW(32)) bus ();

    control_sequencer #(.OPW(5), .IRW(32)) dut (
        .clock (clock),
        .clear (clear),
`ifdef CU_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [27:0] observe();
        return {bus.PCout, bus.IncPC, bus.MARin, bus.read, bus.RAMenable, bus.MDRin,
                bus.MDRout, bus.IRin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                bus.BAout, bus.Yin, bus.Cout, bus.ZLOin, bus.ZLOout, bus.PCin,
                bus.conin, bus.R15in, bus.aluControl, bus.run, bus.illegal};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [20:0] strobes,
                         input logic [4:0] alu, input logic run, input logic ill);
        logic [27:0] exp_v;
        logic [27:0] obs_v;
        exp_v = {strobes, alu, run, ill};
        obs_v = observe();
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
        end
    endtask

    task automatic fetch_from_t0(input logic [31:0] next_ir);
        check("t0", E_T0, 5'd0, 1'b1, 1'b0);
        tick(); check("t1", E_T1, 5'd0, 1'b1, 1'b0);
        bus.ir = next_ir;
        tick(); check("t2", E_T2, 5'd0, 1'b1, 1'b0);
        tick(); check("dec", 21'd0, 5'd0, 1'b1, 1'b0);
    endtask

    initial begin
        clear    = 1'b1;
        bus.ir   = '0;
        bus.con  = 1'b0;
        bus.stop = 1'b0;
        tick(); tick();
        check("reset", 21'd0, 5'd0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();

        // br taken
        bus.con = 1'b1;
        fetch_from_t0(IR_BR);
        tick(); check("br3", S_GRA | S_ROUT | S_CONIN, 5'd0, 1'b1, 1'b0);
        tick(); check("br4", S_PCOUT | S_YIN, 5'd0, 1'b1, 1'b0);
        tick(); check("br5", S_COUT | S_ZLOIN, 5'b00011, 1'b1, 1'b0);
        tick(); check("br6_taken", S_ZLOOUT | S_PCIN, 5'd0, 1'b1, 1'b0);
        tick();

        // br not taken
        bus.con = 1'b0;
        fetch_from_t0(IR_BR);
        tick(); tick(); tick(); tick();
        check("br6_not_taken", S_ZLOOUT, 5'd0, 1'b1, 1'b0);
        tick();

        // add
        fetch_from_t0(IR_ADD);
        tick(); check("alu3", S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, 1'b0);
        tick(); check("alu4", S_GRC | S_ROUT | S_ZLOIN, 5'b00011, 1'b1, 1'b0);
        tick(); check("alu5", S_ZLOOUT | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0);
        tick();

        // jal
        fetch_from_t0(IR_JAL);
        tick(); check("jal3", S_PCOUT | S_R15IN, 5'd0, 1'b1, 1'b0);
        tick(); check("jal4", S_GRA | S_ROUT | S_PCIN, 5'd0, 1'b1, 1'b0);
        tick();

        // nop returns straight to fetch
        fetch_from_t0(IR_NOP);
        tick();

        // illegal opcode pulses for the DEC cycle only
        check("t0_pre_ill", E_T0, 5'd0, 1'b1, 1'b0);
        tick(); bus.ir = IR_ILL;
        tick(); tick();
        check("dec_illegal", 21'd0, 5'd0, 1'b1, 1'b1);
        tick();

        // halt holds until clear
        fetch_from_t0(IR_HALT);
        for (int i = 0; i < 10; i++) begin
            tick(); check("halt_hold", 21'd0, 5'd0, 1'b0, 1'b0);
        end
        clear = 1'b1;
        tick(); check("halt_clear", 21'd0, 5'd0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();

        // clear mid-instruction in BR4
        fetch_from_t0(IR_BR);
        tick(); tick();
        check("br4_pre_clear", S_PCOUT | S_YIN, 5'd0, 1'b1, 1'b0);
        clear = 1'b1;
        tick(); check("mid_clear", 21'd0, 5'd0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();

        // stop during ALU4 lands in HALT after ALU5
        fetch_from_t0(IR_ADD);
        tick(); tick();
        bus.stop = 1'b1;
        tick(); check("alu5_stop", S_ZLOOUT | S_GRA | S_RIN, 5'd0, 1'b1, 1'b0);
        tick(); check("stop_halt", 21'd0, 5'd0, 1'b0, 1'b0);
        bus.stop = 1'b0;
        tick(); check("stop_halt_hold", 21'd0, 5'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the Mini SRC datapath. It produces the per-cycle control strobes that the DataPath module consumes; today those strobes are driven by hand from each testbench.
- Sequences the shared instruction fetch (T0–T2), then the execute steps for the implemented subset:
  - br (conditional branch)
  - jr
  - jal
  - register ALU ops (add/sub/and/or)
  - nop
  - halt
- Sits directly upstream of DataPath. It takes IR and the CON FF output back as inputs.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- IRW, 32, instruction register width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous, active-high reset.
- ir  in  IRW  current IR contents from DataPath.
- con  in  1  CON FF output from DataPath.
- stop  in  1  external stop request.
- PCout, IncPC, MARin, read, RAMenable, MDRin, MDRout, IRin  out  1 each  fetch and memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/enable strobes.
- Yin, Cout, ZLOin, ZLOout, PCin, conin, R15in  out  1 each  execute strobes.
- aluControl  out  5  ALU operation code.
- run  out  1  high while executing; low in RESET_S and HALT.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `clear` is synchronous and active-high.
- States: RESET_S, T0, T1, T2, BR3, BR4, BR5, BR6, ALU3, ALU4, ALU5, JR3, JAL3, JAL4, HALT.
- Output timing: outputs are a pure decode of the registered state, so they are valid for the whole cycle after the posedge entering that state. Any strobe not listed for a state is 0. aluControl is 0 outside ALU4 and BR5.
- Reset:
  - clear=1 at a posedge → state RESET_S, all strobes 0, run=0, illegal=0. This applies from any state, including mid-instruction and HALT.
  - RESET_S → T0 unconditionally on the next edge.
- Fetch (all instructions):
  - T0: PCout, MARin, IncPC.
  - T1: read, RAMenable, MDRin. Memory latency is fixed at one cycle.
  - T2: MDRout, IRin. IR is valid from the next cycle.
- Dispatch at T2 exit, on op = ir[31:27]. At the T2→T3 edge IR is still loading, so the FSM passes through a decode that reads ir on the cycle after T2. Implementation: T2 → DEC (a one-cycle internal state, all strobes 0) → target state. This adds one state to the list above.
  - 00011 add, 00100 sub, 00101 and, 00110 or → ALU3.
  - 10010 br → BR3.
  - 10011 jr → JR3.
  - 10100 jal → JAL3.
  - 11001 nop → end-of-instruction.
  - 11010 halt → HALT.
  - Any other opcode: illegal=1 for the DEC cycle, then end-of-instruction.
- ALU ops:
  - ALU3: Grb, Rout, Yin.
  - ALU4: Grc, Rout, ZLOin, aluControl=op.
  - ALU5: ZLOout, Gra, Rin, then end-of-instruction.
- br:
  - BR3: Gra, Rout, conin.
  - BR4: PCout, Yin.
  - BR5: Cout, aluControl=00011, ZLOin.
  - BR6: ZLOout, PCin=con, then end-of-instruction.
  - con=0 in BR6 means PC keeps PC+1.
- jr: JR3: Gra, Rout, PCin, then end-of-instruction.
- jal:
  - JAL3: PCout, R15in.
  - JAL4: Gra, Rout, PCin, then end-of-instruction.
- End-of-instruction: next state is T0 if stop=0, HALT if stop=1.
  - stop is ignored at every other point, so an instruction is never aborted by stop.
- HALT: all strobes 0, run=0. It is exited only by clear.
- run: 1 in every state except RESET_S and HALT.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit) and state WAIT_S.
  - End-of-instruction goes to WAIT_S instead of T0 (stop still has priority → HALT).
  - WAIT_S holds all strobes 0 and run=1, and advances to T0 on the first cycle with step=1.
  - step held high steps once per instruction, not once per cycle.
  - clear still returns to RESET_S.
- Undefined: no step port, no WAIT_S; behaviour exactly as above.

Test Plan:
- Reset then fetch:
  - Stimulus: clear=1 for 2 cycles, release.
  - Response: RESET_S with all strobes 0 and run=0; next cycles T0 (PCout=MARin=IncPC=1), T1 (read=RAMenable=MDRin=1), T2 (MDRout=IRin=1).
- br taken:
  - Stimulus: ir=0x9000_0005 (op 10010), con=1.
  - Response: BR3 conin=1; BR5 aluControl=00011 and Cout=1; BR6 ZLOout=1 and PCin=1; then T0.
- br not taken:
  - Stimulus: same ir, con=0.
  - Response: BR6 ZLOout=1, PCin=0.
- add:
  - Stimulus: ir=0x1800_0000.
  - Response: ALU3 Grb/Rout/Yin; ALU4 aluControl=00011 with ZLOin; ALU5 Gra/Rin/ZLOout; then T0 if stop=0.
- jal then halt:
  - Stimulus: ir op 10100.
  - Response: JAL3 PCout and R15in; JAL4 PCin.
  - Stimulus: next ir op 11010.
  - Response: HALT with run=0, held for 10 cycles until clear=1 → RESET_S.
- Illegal opcode / mid-instruction reset / stop:
  - Stimulus: op 11111.
  - Response: illegal pulses exactly 1 cycle, then T0.
  - Stimulus: clear asserted in BR4.
  - Response: RESET_S on the next edge with all strobes 0.
  - Stimulus: stop=1 during ALU4.
  - Response: HALT after ALU5, not T0.
